// File: rtl/multdiv_pkg.sv
// multdiv_pkg: shared definitions for the multdiv issue controller.
//   md_state_t              controller state encoding (IDLE/START/WAIT/DONE)
//   OP_MULT / OP_DIV        request opcode values carried on req_op
//   DEFAULT_TIMEOUT_CYCLES  default watchdog limit in WAIT cycles
package multdiv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } md_state_t;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    localparam int DEFAULT_TIMEOUT_CYCLES = 64;

endpackage

// File: rtl/md_watchdog.sv
// md_watchdog: counts WAIT cycles that pass without a result from the multdiv unit.
//   clock, rst_n  clock and asynchronous active-low reset
//   clear         zero the counter (asserted for the START cycle)
//   en            one more cycle has elapsed without md_resultRDY
//   expired       this enabled cycle brings the count to TIMEOUT_CYCLES
module md_watchdog
    import multdiv_pkg::*;
#(
    parameter int CNT_W          = 7,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic clock,
    input  logic rst_n,
    input  logic clear,
    input  logic en,
    output logic expired
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // cnt_q holds the number of completed idle WAIT cycles, so the cycle in
    // which the increment would reach TIMEOUT_CYCLES is the expiry cycle.
    assign expired = en && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/multdiv_issue_ctrl.sv
// multdiv_issue_ctrl: sequences one MULT/DIV at a time into the shared multdiv unit.
//   clock, ctrl_reset_n          clock and asynchronous active-low reset
//   req_valid/ready/op/opA/opB/tag  request handshake from the execute stage
//   flush                        abandon the in-flight operation
//   md_operandA/B, md_ctrl_*     operands and one-cycle start pulses to multdiv
//   md_result/exception/resultRDY  completion from multdiv
//   wb_valid/ack/result/exception/timeout/tag  writeback handshake
//   busy_tag_valid, busy_tag     in-flight destination tag for the hazard interlock
module multdiv_issue_ctrl
    import multdiv_pkg::*;
#(
    parameter int TAG_W          = 5,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int CNT_W          = 7
) (
    input  logic             clock,
    input  logic             ctrl_reset_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_op,
    input  logic [31:0]      req_opA,
    input  logic [31:0]      req_opB,
    input  logic [TAG_W-1:0] req_tag,
    input  logic             flush,
    output logic [31:0]      md_operandA,
    output logic [31:0]      md_operandB,
    output logic             md_ctrl_MULT,
    output logic             md_ctrl_DIV,
    input  logic [31:0]      md_result,
    input  logic             md_exception,
    input  logic             md_resultRDY,
    output logic             wb_valid,
    input  logic             wb_ack,
    output logic [31:0]      wb_result,
    output logic             wb_exception,
    output logic             wb_timeout,
    output logic [TAG_W-1:0] wb_tag,
    output logic             busy_tag_valid,
    output logic [TAG_W-1:0] busy_tag
);

    md_state_t        state_q, state_d;
    logic             op_q;
    logic [31:0]      opa_q, opb_q;
    logic [TAG_W-1:0] tag_q;

    logic accept;
    logic div_by_zero;
    logic wd_clear, wd_en, wd_expired;

    assign req_ready   = (state_q == ST_IDLE);
    assign accept      = req_valid && req_ready;
    assign div_by_zero = (req_op == OP_DIV) && (req_opB == 32'd0);

    // RDY seen during START is stale by definition, so only WAIT counts.
    // RDY has priority over expiry: the counter only advances without it.
    assign wd_clear = (state_q == ST_START);
    assign wd_en    = (state_q == ST_WAIT) && !flush && !md_resultRDY;

    md_watchdog #(
        .CNT_W          (CNT_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clock   (clock),
        .rst_n   (ctrl_reset_n),
        .clear   (wd_clear),
        .en      (wd_en),
        .expired (wd_expired)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = div_by_zero ? ST_DONE : ST_START;
                end
            end
            ST_START: begin
                state_d = flush ? ST_IDLE : ST_WAIT;
            end
            ST_WAIT: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else if (md_resultRDY || wd_expired) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (flush || wb_ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Request latch: held from acceptance until the next acceptance, which
    // keeps the multdiv operands stable from START through DONE.
    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            op_q  <= OP_MULT;
            opa_q <= '0;
            opb_q <= '0;
            tag_q <= '0;
        end else if (accept) begin
            op_q  <= req_op;
            opa_q <= req_opA;
            opb_q <= req_opB;
            tag_q <= req_tag;
        end
    end

    // Start pulses are registered at acceptance so they are high for exactly
    // the START cycle, independent of a flush arriving during START.
    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            md_ctrl_MULT <= 1'b0;
            md_ctrl_DIV  <= 1'b0;
        end else begin
            md_ctrl_MULT <= accept && !div_by_zero && (req_op == OP_MULT);
            md_ctrl_DIV  <= accept && !div_by_zero && (req_op == OP_DIV);
        end
    end

    // Writeback register: loaded on entry to DONE, held until ack or flush.
    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            wb_valid     <= 1'b0;
            wb_result    <= '0;
            wb_exception <= 1'b0;
            wb_timeout   <= 1'b0;
            wb_tag       <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept && div_by_zero) begin
                        wb_valid     <= 1'b1;
                        wb_result    <= '0;
                        wb_exception <= 1'b1;
                        wb_timeout   <= 1'b0;
                        wb_tag       <= req_tag;
                    end
                end
                ST_WAIT: begin
                    if (!flush && md_resultRDY) begin
                        wb_valid     <= 1'b1;
                        wb_result    <= md_result;
                        wb_exception <= md_exception;
                        wb_timeout   <= 1'b0;
                        wb_tag       <= tag_q;
                    end else if (wd_expired) begin
                        wb_valid     <= 1'b1;
                        wb_result    <= '0;
                        wb_exception <= 1'b1;
                        wb_timeout   <= 1'b1;
                        wb_tag       <= tag_q;
                    end
                end
                ST_DONE: begin
                    if (flush || wb_ack) begin
                        wb_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign md_operandA    = opa_q;
    assign md_operandB    = opb_q;
    assign busy_tag_valid = (state_q != ST_IDLE);
    assign busy_tag       = tag_q;

endmodule

// File: tb/tb_multdiv_issue_ctrl.sv
module tb_multdiv_issue_ctrl;
    import multdiv_pkg::*;

    localparam int TAG_W   = 5;
    localparam int TIMEOUT = 64;

    logic             clock = 1'b0;
    logic             ctrl_reset_n;
    logic             req_valid, req_ready, req_op;
    logic [31:0]      req_opA, req_opB;
    logic [TAG_W-1:0] req_tag;
    logic             flush;
    logic [31:0]      md_operandA, md_operandB;
    logic             md_ctrl_MULT, md_ctrl_DIV;
    logic [31:0]      md_result;
    logic             md_exception, md_resultRDY;
    logic             wb_valid, wb_ack;
    logic [31:0]      wb_result;
    logic             wb_exception, wb_timeout;
    logic [TAG_W-1:0] wb_tag;
    logic             busy_tag_valid;
    logic [TAG_W-1:0] busy_tag;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0]      res;
        logic             exc;
        logic             to;
        logic [TAG_W-1:0] tag;
    } exp_t;
    exp_t sb[$];

    always #5 clock = ~clock;

    multdiv_issue_ctrl #(.TAG_W(TAG_W), .TIMEOUT_CYCLES(TIMEOUT), .CNT_W(7)) dut (
        .clock          (clock),
        .ctrl_reset_n   (ctrl_reset_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_op         (req_op),
        .req_opA        (req_opA),
        .req_opB        (req_opB),
        .req_tag        (req_tag),
        .flush          (flush),
        .md_operandA    (md_operandA),
        .md_operandB    (md_operandB),
        .md_ctrl_MULT   (md_ctrl_MULT),
        .md_ctrl_DIV    (md_ctrl_DIV),
        .md_result      (md_result),
        .md_exception   (md_exception),
        .md_resultRDY   (md_resultRDY),
        .wb_valid       (wb_valid),
        .wb_ack         (wb_ack),
        .wb_result      (wb_result),
        .wb_exception   (wb_exception),
        .wb_timeout     (wb_timeout),
        .wb_tag         (wb_tag),
        .busy_tag_valid (busy_tag_valid),
        .busy_tag       (busy_tag)
    );

    // Bus-functional multdiv unit: computes from the operands it sees at the
    // start pulse and raises RDY bfm_delay cycles after the pulse cycle.
    int          bfm_delay = 33;
    bit          bfm_never = 1'b0;
    bit          bfm_hold  = 1'b0;
    bit          bfm_active;
    int          bfm_cnt;
    logic [31:0] bfm_res;
    int          mult_pulses = 0;
    int          div_pulses  = 0;

    assign md_result    = bfm_res;
    assign md_exception = 1'b0;

    always @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            bfm_active   <= 1'b0;
            bfm_cnt      <= 0;
            bfm_res      <= '0;
            md_resultRDY <= 1'b0;
        end else if (md_ctrl_MULT || md_ctrl_DIV) begin
            bfm_active   <= 1'b1;
            bfm_cnt      <= 1;
            md_resultRDY <= 1'b0;
            if (md_ctrl_MULT) bfm_res <= md_operandA * md_operandB;
            else              bfm_res <= $signed(md_operandA) / $signed(md_operandB);
        end else if (bfm_active) begin
            if (bfm_cnt == bfm_delay - 1 && !bfm_never) begin
                md_resultRDY <= 1'b1;
                bfm_active   <= 1'b0;
            end
            bfm_cnt <= bfm_cnt + 1;
        end else if (!bfm_hold) begin
            md_resultRDY <= 1'b0;
        end
    end

    always @(posedge clock) begin
        if (md_ctrl_MULT) mult_pulses++;
        if (md_ctrl_DIV)  div_pulses++;
    end

    // Scoreboard: every consumed writeback must match the oldest expectation.
    always @(negedge clock) begin
        exp_t e;
        #1;
        if (ctrl_reset_n && wb_valid && wb_ack && !flush) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL wb_unexpected: got result=%h exc=%b to=%b tag=%0d, required no writeback",
                         wb_result, wb_exception, wb_timeout, wb_tag);
            end else begin
                e = sb.pop_front();
                if ({wb_result, wb_exception, wb_timeout, wb_tag} !== {e.res, e.exc, e.to, e.tag}) begin
                    errors++;
                    $display("FAIL wb_data: got result=%h exc=%b to=%b tag=%0d, required result=%h exc=%b to=%b tag=%0d",
                             wb_result, wb_exception, wb_timeout, wb_tag, e.res, e.exc, e.to, e.tag);
                end
            end
        end
    end

    task automatic issue(input logic op, input logic [31:0] a, input logic [31:0] b,
                         input logic [TAG_W-1:0] tag);
        @(negedge clock);
        req_valid = 1'b1;
        req_op    = op;
        req_opA   = a;
        req_opB   = b;
        req_tag   = tag;
        @(negedge clock);
        req_valid = 1'b0;
    endtask

    task automatic wait_wb(output int n, input int limit);
        n = 0;
        while (!wb_valid && n < limit) begin
            @(negedge clock);
            n++;
        end
    endtask

    task automatic test_reset();
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b, required 1", req_ready); end
        checks++;
        if (busy_tag_valid !== 1'b0) begin errors++; $display("FAIL reset_busy_valid: got %b, required 0", busy_tag_valid); end
        checks++;
        if (wb_valid !== 1'b0) begin errors++; $display("FAIL reset_wb_valid: got %b, required 0", wb_valid); end
        checks++;
        if ({md_ctrl_MULT, md_ctrl_DIV} !== 2'b00) begin errors++; $display("FAIL reset_ctrl: got %b%b, required 00", md_ctrl_MULT, md_ctrl_DIV); end
        checks++;
        if ({md_operandA, md_operandB} !== 64'd0) begin errors++; $display("FAIL reset_operands: got %h %h, required 0 0", md_operandA, md_operandB); end
        checks++;
        if ({wb_result, wb_exception, wb_timeout, wb_tag, busy_tag} !== '0) begin
            errors++; $display("FAIL reset_wb_fields: got result=%h exc=%b to=%b tag=%0d busy_tag=%0d, required all 0",
                               wb_result, wb_exception, wb_timeout, wb_tag, busy_tag);
        end
    endtask

    task automatic test_basic_mult();
        int m0, d0, n;
        bit busy_drop;
        exp_t e;
        bfm_delay = 33; bfm_never = 0; bfm_hold = 0; wb_ack = 1'b1;
        m0 = mult_pulses; d0 = div_pulses;
        e.res = 32'hFFFF_FFEB; e.exc = 1'b0; e.to = 1'b0; e.tag = 5'd9;
        sb.push_back(e);
        issue(OP_MULT, 32'd7, -32'sd3, 5'd9);
        checks++;
        if (md_ctrl_MULT !== 1'b1 || md_ctrl_DIV !== 1'b0) begin
            errors++; $display("FAIL mult_pulse_start: got MULT=%b DIV=%b, required 1 0", md_ctrl_MULT, md_ctrl_DIV);
        end
        checks++;
        if (busy_tag_valid !== 1'b1 || busy_tag !== 5'd9 || req_ready !== 1'b0) begin
            errors++; $display("FAIL mult_busy_tag: got valid=%b tag=%0d ready=%b, required 1 9 0", busy_tag_valid, busy_tag, req_ready);
        end
        n = 0; busy_drop = 0;
        while (!wb_valid && n < 200) begin
            @(negedge clock);
            n++;
            if (!busy_tag_valid) busy_drop = 1;
        end
        checks++;
        if (n !== 34) begin errors++; $display("FAIL mult_latency: got %0d cycles from pulse, required 34", n); end
        checks++;
        if (busy_drop) begin errors++; $display("FAIL mult_busy_hold: got busy_tag_valid=0 during op, required 1"); end
        @(negedge clock);
        checks++;
        if (busy_tag_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++; $display("FAIL mult_release: got busy=%b ready=%b, required 0 1", busy_tag_valid, req_ready);
        end
        checks++;
        if (mult_pulses - m0 !== 1 || div_pulses - d0 !== 0) begin
            errors++; $display("FAIL mult_pulse_count: got mult=%0d div=%0d, required 1 0", mult_pulses - m0, div_pulses - d0);
        end
    endtask

    task automatic test_div_zero();
        int m0, d0, n;
        exp_t e;
        wb_ack = 1'b1;
        m0 = mult_pulses; d0 = div_pulses;
        e.res = 32'd0; e.exc = 1'b1; e.to = 1'b0; e.tag = 5'd12;
        sb.push_back(e);
        issue(OP_DIV, 32'd100, 32'd0, 5'd12);
        wait_wb(n, 5);
        checks++;
        if (!wb_valid || n > 1) begin
            errors++; $display("FAIL divzero_latency: got wb_valid=%b after %0d extra cycles, required 1 within 1", wb_valid, n);
        end
        repeat (3) @(negedge clock);
        checks++;
        if (mult_pulses != m0 || div_pulses != d0) begin
            errors++; $display("FAIL divzero_no_pulse: got mult=%0d div=%0d pulses, required 0 0", mult_pulses - m0, div_pulses - d0);
        end
    endtask

    task automatic test_timeout();
        int n;
        exp_t e;
        wb_ack = 1'b1; bfm_hold = 0;
        bfm_never = 1;
        e.res = 32'd0; e.exc = 1'b1; e.to = 1'b1; e.tag = 5'd3;
        sb.push_back(e);
        issue(OP_MULT, 32'd5, 32'd6, 5'd3);
        wait_wb(n, 300);
        checks++;
        if (n !== TIMEOUT + 1) begin errors++; $display("FAIL timeout_latency: got %0d, required %0d", n, TIMEOUT + 1); end
        @(negedge clock);
        bfm_never = 0; bfm_delay = TIMEOUT;
        e.res = 32'd30; e.exc = 1'b0; e.to = 1'b0; e.tag = 5'd4;
        sb.push_back(e);
        issue(OP_MULT, 32'd5, 32'd6, 5'd4);
        wait_wb(n, 300);
        checks++;
        if (n !== TIMEOUT + 1 || wb_timeout !== 1'b0) begin
            errors++; $display("FAIL rdy_at_expiry: got latency=%0d timeout=%b, required %0d 0", n, wb_timeout, TIMEOUT + 1);
        end
        @(negedge clock);
    endtask

    task automatic test_stale_backpressure();
        int n;
        bit unstable, ready_seen;
        logic [31:0] r0;
        logic [TAG_W-1:0] t0;
        exp_t e;
        wb_ack = 1'b1; bfm_never = 0; bfm_hold = 1; bfm_delay = 5;
        e.res = 32'd6; e.exc = 1'b0; e.to = 1'b0; e.tag = 5'd1;
        sb.push_back(e);
        issue(OP_MULT, 32'd2, 32'd3, 5'd1);
        wait_wb(n, 50);
        @(negedge clock);
        bfm_delay = 8;
        wb_ack = 1'b0;
        issue(OP_MULT, 32'd4, 32'd5, 5'd2);
        wait_wb(n, 50);
        checks++;
        if (n !== 9) begin errors++; $display("FAIL stale_rdy_latency: got %0d, required 9", n); end
        r0 = wb_result; t0 = wb_tag;
        unstable = 0; ready_seen = 0;
        repeat (5) begin
            @(negedge clock);
            if (!wb_valid || wb_result !== r0 || wb_tag !== t0 || wb_exception !== 1'b0) unstable = 1;
            if (req_ready) ready_seen = 1;
        end
        checks++;
        if (unstable) begin errors++; $display("FAIL backpressure_stable: got changing wb outputs, required stable"); end
        checks++;
        if (ready_seen) begin errors++; $display("FAIL backpressure_ready: got req_ready=1, required 0"); end
        e.res = 32'd20; e.exc = 1'b0; e.to = 1'b0; e.tag = 5'd2;
        sb.push_back(e);
        bfm_hold = 0;
        wb_ack = 1'b1;
        @(negedge clock);
        @(negedge clock);
    endtask

    task automatic test_flush();
        int n, d0;
        exp_t e;
        wb_ack = 1'b1; bfm_never = 0; bfm_hold = 0; bfm_delay = 33;
        issue(OP_MULT, 32'd11, 32'd13, 5'd7);
        repeat (10) @(negedge clock);
        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0;
        checks++;
        if (busy_tag_valid !== 1'b0 || req_ready !== 1'b1 || wb_valid !== 1'b0) begin
            errors++; $display("FAIL flush_idle: got busy=%b ready=%b wb_valid=%b, required 0 1 0", busy_tag_valid, req_ready, wb_valid);
        end
        d0 = div_pulses;
        e.res = 32'd21; e.exc = 1'b0; e.to = 1'b0; e.tag = 5'd8;
        sb.push_back(e);
        issue(OP_DIV, 32'd84, 32'd4, 5'd8);
        checks++;
        if (md_ctrl_DIV !== 1'b1 || md_ctrl_MULT !== 1'b0) begin
            errors++; $display("FAIL flush_div_pulse: got DIV=%b MULT=%b, required 1 0", md_ctrl_DIV, md_ctrl_MULT);
        end
        wait_wb(n, 200);
        checks++;
        if (n !== 34) begin errors++; $display("FAIL flush_div_latency: got %0d, required 34", n); end
        @(negedge clock);
        checks++;
        if (div_pulses - d0 !== 1) begin errors++; $display("FAIL flush_div_count: got %0d, required 1", div_pulses - d0); end
    endtask

    task automatic test_async_reset();
        wb_ack = 1'b1; bfm_delay = 33;
        issue(OP_MULT, 32'd9, 32'd9, 5'd5);
        repeat (5) @(negedge clock);
        #2;
        ctrl_reset_n = 1'b0;
        #1;
        checks++;
        if (busy_tag_valid !== 1'b0 || busy_tag !== '0 || wb_valid !== 1'b0) begin
            errors++; $display("FAIL async_reset_state: got busy=%b tag=%0d wb_valid=%b, required 0 0 0", busy_tag_valid, busy_tag, wb_valid);
        end
        checks++;
        if ({md_operandA, md_operandB} !== 64'd0 || {md_ctrl_MULT, md_ctrl_DIV} !== 2'b00) begin
            errors++; $display("FAIL async_reset_md: got A=%h B=%h ctrl=%b%b, required 0", md_operandA, md_operandB, md_ctrl_MULT, md_ctrl_DIV);
        end
        @(negedge clock);
        ctrl_reset_n = 1'b1;
        @(negedge clock);
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL async_reset_ready: got %b, required 1", req_ready); end
    endtask

    initial begin
        ctrl_reset_n = 1'b0;
        req_valid = 1'b0; req_op = 1'b0; req_opA = '0; req_opB = '0; req_tag = '0;
        flush = 1'b0; wb_ack = 1'b1;
        repeat (3) @(negedge clock);
        ctrl_reset_n = 1'b1;
        @(negedge clock);
        test_reset();
        test_basic_mult();
        test_div_zero();
        test_timeout();
        test_stale_backpressure();
        test_flush();
        test_async_reset();
        repeat (3) @(negedge clock);
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL sb_drain: got %0d pending writebacks, required 0", sb.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: got no completion, required finish");
        $fatal(1, "bench time limit exceeded");
    end

endmodule
